// File: rtl/spi_slave_control.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// spi_slave_control
//
// SPI mode-0 slave endpoint, the board-side partner of our SPI master
// controller. Bytes arrive MSB-first on SCLK/MOSI while SS is low. The last
// complete byte is held in rx_byte, shown on the active-low LEDs, and echoed
// back on MISO during the following byte so the master can read it back.
// The SPI pins are asynchronous to clk and are synchronised internally, so
// clk must run at least 4x the SCLK frequency. A debounced active-low push
// button clears the stored byte and the byte count.
//
// Parameters
//   DEBOUNCE_BITS  width of the clear-button debounce counter; the clear
//                  fires when bit [DEBOUNCE_BITS-1] sets
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   clear       in   push button, active-low, undebounced
//   SCLK        in   SPI clock from the master, idle low
//   MOSI        in   SPI data from the master
//   SS          in   slave select, active-low
//   MISO        out  SPI data to the master (never tri-stated)
//   led         out  ~rx_byte[5:0] for the active-low LEDs
//   rx_byte     out  last complete byte received
//   rx_valid    out  one-clk pulse when rx_byte updates
//   byte_count  out  number of bytes received, modulo 256
// ---------------------------------------------------------------------------
module spi_slave_control #(
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO,
    output logic [5:0] led,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] byte_count
);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    localparam logic [DEBOUNCE_BITS-1:0] DEB_ONE = 1;

    // Synchroniser pipelines: bit 0 is s1, bit 1 is s2, bit 2 is s3.
    logic [2:0] sclk_pipe_q, sclk_pipe_d;
    logic [2:0] ss_pipe_q,   ss_pipe_d;
    logic [1:0] mosi_pipe_q, mosi_pipe_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    // Only seven bits of history are needed: the eighth bit completes the
    // byte straight from MOSI into rx_byte.
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] byte_count_q, byte_count_d;
    logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;

    logic sclk_rise, sclk_fall;
    logic ss_rise, ss_fall;
    logic mosi_sync;
    logic [DEBOUNCE_BITS-1:0] deb_cnt_inc;
    logic clear_fire;

    // Edge detection works on the s2/s3 pair so that the metastable s1 stage
    // never feeds any decision logic.
    always_comb begin
        sclk_rise   = sclk_pipe_q[1] & ~sclk_pipe_q[2];
        sclk_fall   = ~sclk_pipe_q[1] & sclk_pipe_q[2];
        ss_rise     = ss_pipe_q[1] & ~ss_pipe_q[2];
        ss_fall     = ~ss_pipe_q[1] & ss_pipe_q[2];
        mosi_sync   = mosi_pipe_q[1];
        deb_cnt_inc = deb_cnt_q + DEB_ONE;
        // One-shot on the single cycle in which the counter's top bit is
        // about to set; afterwards the counter parks with the top bit high,
        // so holding the button never retriggers.
        clear_fire  = ~clear & ~deb_cnt_q[DEBOUNCE_BITS-1]
                      & deb_cnt_inc[DEBOUNCE_BITS-1];
    end

    // Next-state logic: synchronisers, debounce counter and the transfer FSM.
    // The debounced clear is applied last so that it overrides a byte
    // completing in the same cycle, including its rx_valid pulse.
    always_comb begin
        sclk_pipe_d  = {sclk_pipe_q[1:0], SCLK};
        ss_pipe_d    = {ss_pipe_q[1:0], SS};
        mosi_pipe_d  = {mosi_pipe_q[0], MOSI};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        byte_count_d = byte_count_q;
        deb_cnt_d    = deb_cnt_q;

        if (clear) begin
            deb_cnt_d = '0;
        end else if (!deb_cnt_q[DEBOUNCE_BITS-1]) begin
            deb_cnt_d = deb_cnt_inc;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (ss_fall) begin
                    state_d    = ST_ACTIVE;
                    tx_shift_d = rx_byte_q;
                end
            end
            ST_ACTIVE: begin
                // Deselect takes priority over any SCLK edge in the same
                // cycle; a partially shifted byte is simply dropped.
                if (ss_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[5:0], mosi_sync};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_d    = {rx_shift_q, mosi_sync};
                        rx_valid_d   = 1'b1;
                        byte_count_d = byte_count_q + 8'd1;
                    end
                end else if (sclk_fall) begin
                    // bit_cnt of 0 on a falling edge means a byte has just
                    // completed: reload the echo register with it so the
                    // master reads it back during the next byte.
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_d = rx_byte_q;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
            end
        endcase

        if (clear_fire) begin
            rx_byte_d    = 8'd0;
            byte_count_d = 8'd0;
            rx_valid_d   = 1'b0;
        end
    end

    // State register. SS stages reset high and SCLK stages low so that the
    // first cycles after reset never see a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe_q  <= 3'b000;
            ss_pipe_q    <= 3'b111;
            mosi_pipe_q  <= 2'b00;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            tx_shift_q   <= 8'd0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            byte_count_q <= 8'd0;
            deb_cnt_q    <= '0;
        end else begin
            sclk_pipe_q  <= sclk_pipe_d;
            ss_pipe_q    <= ss_pipe_d;
            mosi_pipe_q  <= mosi_pipe_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            byte_count_q <= byte_count_d;
            deb_cnt_q    <= deb_cnt_d;
        end
    end

    // MISO is driven low whenever the slave is deselected.
    always_comb begin
        MISO       = (state_q == ST_ACTIVE) & tx_shift_q[7];
        led        = ~rx_byte_q[5:0];
        rx_byte    = rx_byte_q;
        rx_valid   = rx_valid_q;
        byte_count = byte_count_q;
    end

endmodule

// File: tb/tb_spi_slave_control.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_spi_slave_control
//
// Directed bench for the SPI mode-0 slave. Acts as the SPI master at clk/8,
// drives the clear button, and checks the slave's outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_slave_control;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic       miso;
    logic [5:0] led;
    logic [7:0] rxByte;
    logic       rxValid;
    logic [7:0] byteCount;

    int compared   = 0;
    int mismatched = 0;
    int validCount = 0;

    spi_slave_control #(
        .DEBOUNCE_BITS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .SCLK       (sclk),
        .MOSI       (mosi),
        .SS         (ss),
        .MISO       (miso),
        .led        (led),
        .rx_byte    (rxByte),
        .rx_valid   (rxValid),
        .byte_count (byteCount)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rx_valid cycles, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rxValid === 1'b1) validCount <= validCount + 1;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives all inputs at a falling clk edge.
    task automatic applyStimulus(input logic rstV, input logic ssV,
                                 input logic sclkV, input logic mosiV,
                                 input logic clearV);
        rst   = rstV;
        ss    = ssV;
        sclk  = sclkV;
        mosi  = mosiV;
        clear = clearV;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        waitClk(2);
        rst = 1'b0;
        waitClk(2);
    endtask

    task automatic frameStart();
        ss = 1'b0;
        waitClk(4);
    endtask

    task automatic frameEnd();
        waitClk(4);
        ss = 1'b1;
        waitClk(4);
    endtask

    // Shifts the top nbits of tx out MSB-first (4 clk low, 4 clk high per
    // bit) and returns what the master sampled on MISO at each rising edge.
    task automatic spiBits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] misoByte);
        misoByte = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            waitClk(4);
            misoByte[7-i] = miso;
            sclk = 1'b1;
            waitClk(4);
            sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int         v0;

        // Reset with SS high.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        waitClk(3);
        checkOutput("reset_led", led, 6'h3F);
        checkOutput("reset_rx_byte", rxByte, 8'h00);
        checkOutput("reset_count", byteCount, 8'h00);
        checkOutput("reset_miso", miso, 1'b0);
        checkOutput("reset_valid", rxValid, 1'b0);
        rst = 1'b0;
        waitClk(2);

        // Single byte A5.
        v0 = validCount;
        frameStart();
        spiBits(8'hA5, 8, m1);
        frameEnd();
        checkOutput("a5_valid_pulses", validCount - v0, 1);
        checkOutput("a5_rx_byte", rxByte, 8'hA5);
        checkOutput("a5_led", led, 6'h1A);
        checkOutput("a5_count", byteCount, 8'h01);
        checkOutput("a5_echo_read", m1, 8'h00);

        // Two bytes in one frame, echo of the first during the second.
        doReset();
        v0 = validCount;
        frameStart();
        spiBits(8'h3C, 8, m1);
        spiBits(8'h81, 8, m2);
        frameEnd();
        checkOutput("echo_first_read", m1, 8'h00);
        checkOutput("echo_second_read", m2, 8'h3C);
        checkOutput("two_count", byteCount, 8'h02);
        checkOutput("two_rx_byte", rxByte, 8'h81);
        checkOutput("two_valid_pulses", validCount - v0, 2);
        checkOutput("two_led", led, 6'h3E);
        checkOutput("idle_miso", miso, 1'b0);

        // Partial byte is discarded.
        v0 = validCount;
        frameStart();
        spiBits(8'hFF, 5, m1);
        frameEnd();
        checkOutput("partial_valid_pulses", validCount - v0, 0);
        checkOutput("partial_rx_byte", rxByte, 8'h81);
        checkOutput("partial_count", byteCount, 8'h02);
        frameStart();
        spiBits(8'h12, 8, m1);
        frameEnd();
        checkOutput("after_partial_echo", m1, 8'h81);
        checkOutput("after_partial_rx_byte", rxByte, 8'h12);
        checkOutput("after_partial_count", byteCount, 8'h03);

        // Clear glitch one cycle too short.
        clear = 1'b0;
        waitClk(7);
        clear = 1'b1;
        waitClk(3);
        checkOutput("glitch_rx_byte", rxByte, 8'h12);
        checkOutput("glitch_count", byteCount, 8'h03);

        // Clear held exactly long enough, then kept held through a byte.
        clear = 1'b0;
        waitClk(8);
        checkOutput("clear_rx_byte", rxByte, 8'h00);
        checkOutput("clear_count", byteCount, 8'h00);
        frameStart();
        spiBits(8'h77, 8, m1);
        frameEnd();
        checkOutput("held_echo", m1, 8'h00);
        checkOutput("held_rx_byte", rxByte, 8'h77);
        checkOutput("held_count", byteCount, 8'h01);
        checkOutput("held_led", led, 6'h08);
        clear = 1'b1;
        waitClk(2);

        // 256 bytes in one frame: the count wraps to zero.
        doReset();
        v0 = validCount;
        frameStart();
        for (int k = 0; k < 255; k++) begin
            spiBits(8'(k), 8, m1);
        end
        checkOutput("wrap_count_255", byteCount, 8'hFF);
        checkOutput("wrap_echo_254", m1, 8'hFD);
        spiBits(8'hFF, 8, m2);
        checkOutput("wrap_echo_255", m2, 8'hFE);
        checkOutput("wrap_count_0", byteCount, 8'h00);
        checkOutput("wrap_rx_byte", rxByte, 8'hFF);
        frameEnd();
        checkOutput("wrap_valid_pulses", validCount - v0, 256);

        // Reset in the middle of a byte.
        frameStart();
        spiBits(8'hC3, 3, m1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        waitClk(2);
        checkOutput("midrst_rx_byte", rxByte, 8'h00);
        checkOutput("midrst_count", byteCount, 8'h00);
        checkOutput("midrst_led", led, 6'h3F);
        checkOutput("midrst_miso", miso, 1'b0);
        checkOutput("midrst_valid", rxValid, 1'b0);
        rst = 1'b0;
        waitClk(2);
        frameStart();
        spiBits(8'h5A, 8, m1);
        frameEnd();
        checkOutput("post_rst_rx_byte", rxByte, 8'h5A);
        checkOutput("post_rst_count", byteCount, 8'h01);
        checkOutput("post_rst_led", led, 6'h25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
